ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 180 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-bit frame, ack, release.
// Define PS2_HOST_TX_TIMEOUT_EN to build the device-clock watchdog; otherwise timeout is tied low.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clock50,
    input  logic       reset,
    input  logic       write,
    input  logic [7:0] tx_data,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_XFER, S_ACK, S_RELEASE
    } state_t;

    localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES + 1) : 1;

    state_t      state_q, state_d;
    logic [2:0]  clk_sync_q, clk_sync_d;
    logic [1:0]  dat_sync_q, dat_sync_d;
    logic [7:0]  data_q, data_d;
    logic        par_q, par_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [IW-1:0] inh_cnt_q, inh_cnt_d;
    logic        dat_oe_q, dat_oe_d;
    logic        done_q, done_d;
    logic        ack_err_q, ack_err_d;
    logic        fall;

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd_q, wd_d;
    logic          timeout_q, timeout_d;
`endif

    // clk_sync_q[2] is the previous synced level, so fall marks a synced 1->0
    assign fall       = clk_sync_q[2] & ~clk_sync_q[1];
    assign clk_sync_d = {clk_sync_q[1:0], ps2_clk_in};
    assign dat_sync_d = {dat_sync_q[0], ps2_dat_in};

    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            clk_sync_q <= '0;
            dat_sync_q <= '0;
            data_q     <= '0;
            par_q      <= 1'b0;
            bit_cnt_q  <= '0;
            inh_cnt_q  <= '0;
            dat_oe_q   <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
            wd_q       <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            data_q     <= data_d;
            par_q      <= par_d;
            bit_cnt_q  <= bit_cnt_d;
            inh_cnt_q  <= inh_cnt_d;
            dat_oe_q   <= dat_oe_d;
            done_q     <= done_d;
            ack_err_q  <= ack_err_d;
`ifdef PS2_HOST_TX_TIMEOUT_EN
            wd_q       <= wd_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        par_d     = par_q;
        bit_cnt_d = bit_cnt_q;
        inh_cnt_d = inh_cnt_q;
        dat_oe_d  = dat_oe_q;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;
`ifdef PS2_HOST_TX_TIMEOUT_EN
        wd_d      = wd_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                // a write coinciding with the done pulse is deliberately dropped
                if (write && !done_q) begin
                    data_d    = tx_data;
                    par_d     = ~^tx_data;
                    ack_err_d = 1'b0;
                    inh_cnt_d = '0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (inh_cnt_q == IW'(INHIBIT_CYCLES - 1)) begin
                    dat_oe_d = 1'b1;
                    state_d  = S_REQ;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end
            S_REQ: begin
                bit_cnt_d = '0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
                wd_d      = '0;
`endif
                state_d   = S_XFER;
            end
            S_XFER: begin
                if (fall) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q < 4'd8) begin
                        dat_oe_d = ~data_q[bit_cnt_q[2:0]];
                    end else if (bit_cnt_q == 4'd8) begin
                        dat_oe_d = ~par_q;
                    end else begin
                        dat_oe_d = 1'b0;
                        state_d  = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (fall) begin
                    ack_err_d = dat_sync_q[1];
                    state_d   = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (clk_sync_q[1] && dat_sync_q[1]) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef PS2_HOST_TX_TIMEOUT_EN
        // wd counts the fall cycle as 1, so done lands TIMEOUT_CYCLES cycles after it
        if (state_q == S_XFER || state_q == S_ACK || state_q == S_RELEASE) begin
            wd_d = fall ? WW'(1) : wd_q + 1'b1;
            if (!fall && state_d != S_IDLE && wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
                state_d   = S_IDLE;
                dat_oe_d  = 1'b0;
                timeout_d = 1'b1;
                done_d    = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        ps2_clk_oe = (state_q == S_INHIBIT) || (state_q == S_REQ);
        ps2_dat_oe = dat_oe_q;
        busy       = (state_q != S_IDLE);
        done       = done_q;
        ack_err    = ack_err_q;
`ifdef PS2_HOST_TX_TIMEOUT_EN
        timeout    = timeout_q;
`else
        timeout    = 1'b0;
`endif
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized bench for ps2_host_tx: a behavioural PS/2 device clocks the frame out and
// the captured line levels are compared with the frame built from the byte.
module tb_ps2_host_tx;

    localparam int INH = 300;
    localparam int TMO = 3000;

    logic       clock50 = 1'b0;
    logic       reset   = 1'b1;
    logic       write   = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_oe, ps2_dat_oe, busy, done, ack_err, timeout;

    // open-drain wired-AND of host pull-down and device
    assign ps2_clk_in = ~ps2_clk_oe & dev_clk;
    assign ps2_dat_in = ~ps2_dat_oe & dev_dat;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clock50(clock50), .reset(reset), .write(write), .tx_data(tx_data),
        .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe),
        .busy(busy), .done(done), .ack_err(ack_err), .timeout(timeout)
    );

    always #10 clock50 = ~clock50;

    int cyc = 0;
    always @(posedge clock50) cyc <= cyc + 1;

    int done_cnt = 0;
    always @(negedge clock50) if (done) done_cnt <= done_cnt + 1;

    int total = 0, bad = 0;
    logic [10:0] frame;
    int inh_n, req_n, fall_cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic issue_write(input logic [7:0] d);
        write   = 1'b1;
        tx_data = d;
        @(negedge clock50);
        write   = 1'b0;
    endtask

    // device: waits for request-to-send, then reads each bit at the end of the clock-high phase
    task automatic run_device(input int h, input bit ack, input int max_falls);
        bit rts = 1'b0;
        inh_n = 0;
        req_n = 0;
        frame = '0;
        for (int k = 0; k < INH + 50; k++) begin
            if (ps2_clk_oe && !ps2_dat_oe) inh_n++;
            else if (ps2_clk_oe && ps2_dat_oe) req_n++;
            else if (!ps2_clk_oe && ps2_dat_oe) begin
                rts = 1'b1;
                break;
            end
            @(negedge clock50);
        end
        chk("rts_seen", rts, 1);
        if (!rts) return;
        for (int i = 0; i < 11 && i < max_falls; i++) begin
            repeat (h) @(negedge clock50);
            frame[i] = ps2_dat_in;
            if (i == 10 && ack) begin
                dev_dat = 1'b0;
                repeat (h) @(negedge clock50);
            end
            dev_clk  = 1'b0;
            fall_cyc = cyc;
            repeat (h) @(negedge clock50);
            dev_clk = 1'b1;
            dev_dat = 1'b1;
        end
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock50);
        end
    endtask

    task automatic do_tx(input logic [7:0] d, input bit ack, input int h,
                         input bit issue, input bit mid);
        int snap;
        bit seen;
        bit par;
        logic [10:0] exp_f;
        par   = ($countones(d) % 2 == 0);
        exp_f = {1'b1, par, d, 1'b0};
        snap  = done_cnt;
        if (issue) issue_write(d);
        chk("accepted", busy, 1);
        chk("flags_clr", {ack_err, timeout}, 0);
        fork
            run_device(h, ack, 11);
            begin
                if (mid) begin
                    repeat (INH + 80) @(negedge clock50);
                    write   = 1'b1;
                    tx_data = 8'h00;
                    @(negedge clock50);
                    write   = 1'b0;
                end
            end
        join
        wait_done(200, seen);
        chk("done_seen", seen, 1);
        chk("frame", frame, exp_f);
        chk("inhibit_len", inh_n, INH);
        chk("req_len", req_n, 1);
        chk("ack_err", ack_err, !ack);
        chk("timeout", timeout, 0);
        repeat (5) @(negedge clock50);
        chk("done_once", done_cnt - snap, 1);
        chk("idle", {busy, ps2_clk_oe, ps2_dat_oe}, 0);
        chk("ack_err_held", ack_err, !ack);
    endtask

    initial begin
        #(20 * 90000);
        $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "bench timeout");
    end

    initial begin
        bit seen;
        logic [7:0] rd;
        repeat (3) @(negedge clock50);
        chk("rst_outs", {ps2_clk_oe, ps2_dat_oe, busy, done, ack_err, timeout}, 0);
        reset = 1'b0;

        // first write right on the first edge after reset
        do_tx(8'hED, 1'b1, 10, 1'b1, 1'b0);
        do_tx(8'hF4, 1'b0, 12, 1'b1, 1'b0);
        do_tx(8'hED, 1'b1, 10, 1'b1, 1'b1);

        // write in the done cycle is dropped, the one in the next cycle is taken
        issue_write(8'h11);
        run_device(9, 1'b1, 11);
        wait_done(200, seen);
        chk("done_pre36", seen, 1);
        write   = 1'b1;
        tx_data = 8'h5A;
        @(negedge clock50);
        chk("done_cyc_wr", busy, 0);
        tx_data = 8'hA5;
        @(negedge clock50);
        chk("next_cyc_wr", busy, 1);
        write = 1'b0;
        do_tx(8'hA5, 1'b1, 10, 1'b0, 1'b0);

        // asynchronous reset mid-transfer
        rd = 8'($urandom);
        issue_write(rd);
        run_device(12, 1'b1, 4);
        chk("busy_pre_rst", busy, 1);
        #3 reset = 1'b1;
        #1 chk("rst_async", {ps2_clk_oe, ps2_dat_oe, busy, done}, 0);
        @(negedge clock50);
        reset = 1'b0;
        do_tx(8'hFF, 1'b1, 11, 1'b1, 1'b0);

`ifdef PS2_HOST_TX_TIMEOUT_EN
        issue_write(8'h3C);
        run_device(10, 1'b1, 5);
        wait_done(TMO + 200, seen);
        chk("wd_done", seen, 1);
        // 2-flop sync adds two cycles between the line fall and the synced fall cycle
        chk("wd_latency", cyc - fall_cyc, TMO + 2);
        chk("wd_flag", {timeout, ack_err}, 2'b10);
        chk("wd_release", {ps2_clk_oe, ps2_dat_oe}, 0);
        @(negedge clock50);
        chk("wd_idle", busy, 0);
`endif

        for (int n = 0; n < 6; n++) begin
            do_tx(8'($urandom), 1'($urandom), $urandom_range(8, 24), 1'b1, 1'b0);
            repeat ($urandom_range(0, 5)) @(negedge clock50);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
